// File: rtl/xrog_pkg.sv
// Shared types and scaling constants for the XROG orbit stability calculator.
package xrog_pkg;

   localparam int unsigned IDX_MAX = 1000;
   localparam int unsigned SCALE   = 1000;

   typedef enum logic [1:0] {
      NORMAL,
      WARN,
      ALERT
   } region_e;

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      DIV_C,
      DIV_I,
      OUT
   } state_e;

endpackage

// File: rtl/xrog_serial_div.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses DIV_W+1
// cycles after the start edge. A zero divisor is flagged rather than trapped.
module xrog_serial_div #(
   parameter int unsigned DIV_W = 49
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [DIV_W-1:0] dividend_i,
   input  logic [DIV_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DIV_W-1:0] quotient_o,
   output logic             dz_o
);

   localparam int unsigned CNT_W = $clog2(DIV_W + 1);

   logic [DIV_W-1:0] rem_q, rem_d;
   logic [DIV_W-1:0] quo_q, quo_d;
   logic [DIV_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [DIV_W:0]   rem_sh;
   logic [DIV_W:0]   trial;

   always_comb begin
      rem_sh = {rem_q, quo_q[DIV_W-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      dz_d   = dz_q;
      done_d = 1'b0;
      if (start_i) begin
         rem_d  = '0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
         dz_d   = (divisor_i == '0);
         cnt_d  = CNT_W'(DIV_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Sign bit of the trial subtraction decides restore vs. keep.
         if (!trial[DIV_W]) begin
            rem_d = trial[DIV_W-1:0];
            quo_d = {quo_q[DIV_W-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[DIV_W-1:0];
            quo_d = {quo_q[DIV_W-2:0], 1'b0};
         end
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         dz_q   <= dz_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign quotient_o = quo_q;
   assign dz_o       = dz_q;

endmodule

// File: rtl/xrog_orbit_stability_mc.sv
// Weighted multi-channel drift averaging with a saturated stability index and
// hysteretic warning / debounced alert flags; one serial divider is shared.
module xrog_orbit_stability_mc
   import xrog_pkg::*;
#(
   parameter int unsigned NUM_CH     = 5,
   parameter int unsigned DRIFT_W    = 32,
   parameter int unsigned NUM_ORBIT  = 8,
   parameter int unsigned WGT_W      = 4,
   parameter int unsigned ALERT_CNT  = 3,
   parameter int unsigned HYST_SHIFT = 3,
   localparam int unsigned OW        = $clog2(NUM_ORBIT),
   localparam int unsigned CHW       = $clog2(NUM_CH)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [OW-1:0]             orbit_type_i,
   input  logic [NUM_CH*DRIFT_W-1:0] drift_i,
   input  logic [DRIFT_W-1:0]        stability_envelope_i,
   input  logic [DRIFT_W-1:0]        drift_threshold_i,
   input  logic                      wgt_we_i,
   input  logic [OW-1:0]             wgt_orbit_i,
   input  logic [CHW-1:0]            wgt_ch_i,
   input  logic [WGT_W-1:0]          wgt_data_i,
   output logic                      wgt_drop_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [DRIFT_W-1:0]        composite_drift_o,
   output logic [15:0]               stability_index_o,
   output logic                      drift_warning_o,
   output logic                      instability_alert_o,
   output logic                      busy_o
);

   localparam int unsigned DIV_W = DRIFT_W + WGT_W + $clog2(NUM_CH) + 10;
   localparam int unsigned CNTW  = $clog2(ALERT_CNT + 1);

   state_e               state_q, state_d;
   logic [DRIFT_W-1:0]   drift_q [NUM_CH];
   logic [DRIFT_W-1:0]   drift_d [NUM_CH];
   logic [OW-1:0]        orbit_q, orbit_d;
   logic [DRIFT_W-1:0]   env_q, env_d;
   logic [DRIFT_W-1:0]   thr_q, thr_d;
   logic [DIV_W-1:0]     sum_q, sum_d;
   logic [DIV_W-1:0]     wsum_q, wsum_d;
   logic [CHW-1:0]       ch_q, ch_d;
   logic [DRIFT_W-1:0]   comp_q, comp_d;
   region_e              region_q, region_d;
   logic [DRIFT_W-1:0]   comp_out_q, comp_out_d;
   logic [15:0]          idx_q, idx_d;
   logic                 warn_q, warn_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 drop_q, drop_d;
   logic [WGT_W-1:0]     wgt_q [NUM_ORBIT][NUM_CH];

   logic                 wgt_wr;
   logic [DRIFT_W-1:0]   drift_sel;
   logic [WGT_W-1:0]     w_sel;
   logic [DIV_W-1:0]     prod;
   logic [DRIFT_W-1:0]   comp_c;
   region_e              region_c;
   logic [DRIFT_W-1:0]   den_c;
   logic [DIV_W-1:0]     q_c;
   logic [15:0]          idx_c;
   logic [DRIFT_W-1:0]   hyst_lim;

   logic                 div_start;
   logic [DIV_W-1:0]     div_dividend;
   logic [DIV_W-1:0]     div_divisor;
   logic                 div_busy;
   logic                 div_done;
   logic [DIV_W-1:0]     div_quo;
   logic                 div_dz;

   xrog_serial_div #(.DIV_W(DIV_W)) u_div (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (div_start),
      .dividend_i (div_dividend),
      .divisor_i  (div_divisor),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quo),
      .dz_o       (div_dz)
   );

   assign wgt_wr = wgt_we_i && (state_q == IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned o = 0; o < NUM_ORBIT; o++)
            for (int unsigned c = 0; c < NUM_CH; c++)
               wgt_q[o][c] <= WGT_W'(1);
      end else if (wgt_wr) begin
         for (int unsigned o = 0; o < NUM_ORBIT; o++)
            for (int unsigned c = 0; c < NUM_CH; c++)
               if (wgt_orbit_i == OW'(o) && wgt_ch_i == CHW'(c))
                  wgt_q[o][c] <= wgt_data_i;
      end
   end

   // Unknown orbit rows fall through to the uniform weight of 1.
   always_comb begin
      drift_sel = '0;
      w_sel     = WGT_W'(1);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (ch_q == CHW'(c)) begin
            drift_sel = drift_q[c];
            for (int unsigned o = 0; o < NUM_ORBIT; o++)
               if (orbit_q == OW'(o))
                  w_sel = wgt_q[o][c];
         end
      end
      prod = DIV_W'(drift_sel) * DIV_W'(w_sel);
   end

   always_comb begin
      if (div_dz)
         comp_c = '0;
      else if (|div_quo[DIV_W-1:DRIFT_W])
         comp_c = '1;
      else
         comp_c = div_quo[DRIFT_W-1:0];
      if (comp_c < env_q)
         region_c = NORMAL;
      else if (comp_c < thr_q)
         region_c = WARN;
      else
         region_c = ALERT;
      den_c    = (region_c == NORMAL) ? env_q : thr_q;
      q_c      = div_dz ? DIV_W'(IDX_MAX) : div_quo;
      idx_c    = (q_c >= DIV_W'(IDX_MAX)) ? '0 : 16'(DIV_W'(IDX_MAX) - q_c);
      hyst_lim = env_q - (env_q >> HYST_SHIFT);
   end

   always_comb begin
      state_d      = state_q;
      drift_d      = drift_q;
      orbit_d      = orbit_q;
      env_d        = env_q;
      thr_d        = thr_q;
      sum_d        = sum_q;
      wsum_d       = wsum_q;
      ch_d         = ch_q;
      comp_d       = comp_q;
      region_d     = region_q;
      comp_out_d   = comp_out_q;
      idx_d        = idx_q;
      warn_d       = warn_q;
      cnt_d        = cnt_q;
      drop_d       = wgt_we_i && (state_q != IDLE);
      div_start    = 1'b0;
      div_dividend = '0;
      div_divisor  = '0;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               for (int unsigned c = 0; c < NUM_CH; c++)
                  drift_d[c] = drift_i[c*DRIFT_W +: DRIFT_W];
               orbit_d = orbit_type_i;
               env_d   = stability_envelope_i;
               thr_d   = drift_threshold_i;
               sum_d   = '0;
               wsum_d  = '0;
               ch_d    = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            sum_d  = sum_q + prod;
            wsum_d = wsum_q + DIV_W'(w_sel);
            ch_d   = ch_q + CHW'(1);
            if (ch_q == CHW'(NUM_CH - 1))
               state_d = DIV_C;
         end
         DIV_C: begin
            // Index divide launches on the same edge the composite divide
            // finishes, keeping the total latency fixed.
            if (div_done) begin
               comp_d       = comp_c;
               region_d     = region_c;
               div_start    = 1'b1;
               div_dividend = DIV_W'(comp_c) * DIV_W'(SCALE);
               div_divisor  = DIV_W'(den_c);
               state_d      = DIV_I;
            end else if (!div_busy) begin
               div_start    = 1'b1;
               div_dividend = sum_q;
               div_divisor  = wsum_q;
            end
         end
         DIV_I: begin
            if (div_done) begin
               comp_out_d = comp_q;
               idx_d      = idx_c;
               if (region_q != NORMAL)
                  warn_d = 1'b1;
               else if (comp_q < hyst_lim)
                  warn_d = 1'b0;
               if (region_q == ALERT)
                  cnt_d = (cnt_q == CNTW'(ALERT_CNT)) ? cnt_q : cnt_q + CNTW'(1);
               else
                  cnt_d = '0;
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         for (int unsigned c = 0; c < NUM_CH; c++)
            drift_q[c] <= '0;
         orbit_q    <= '0;
         env_q      <= '0;
         thr_q      <= '0;
         sum_q      <= '0;
         wsum_q     <= '0;
         ch_q       <= '0;
         comp_q     <= '0;
         region_q   <= NORMAL;
         comp_out_q <= '0;
         idx_q      <= 16'(IDX_MAX);
         warn_q     <= 1'b0;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         drift_q    <= drift_d;
         orbit_q    <= orbit_d;
         env_q      <= env_d;
         thr_q      <= thr_d;
         sum_q      <= sum_d;
         wsum_q     <= wsum_d;
         ch_q       <= ch_d;
         comp_q     <= comp_d;
         region_q   <= region_d;
         comp_out_q <= comp_out_d;
         idx_q      <= idx_d;
         warn_q     <= warn_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
      end
   end

   assign in_ready_o          = (state_q == IDLE) && !rst_i;
   assign out_valid_o         = (state_q == OUT);
   assign busy_o              = (state_q != IDLE);
   assign wgt_drop_o          = drop_q;
   assign composite_drift_o   = comp_out_q;
   assign stability_index_o   = idx_q;
   assign drift_warning_o     = warn_q;
   assign instability_alert_o = (cnt_q == CNTW'(ALERT_CNT));

endmodule

// File: tb/tb_xrog_orbit_stability_mc.sv
// Bench for xrog_orbit_stability_mc: directed scenarios plus random samples
// scored against an arithmetic model of weighted mean, region and flags.
module tb_xrog_orbit_stability_mc;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    orbit_type;
   logic [159:0]  drift;
   logic [31:0]   env;
   logic [31:0]   thr;
   logic          wgt_we;
   logic [2:0]    wgt_orbit;
   logic [2:0]    wgt_ch;
   logic [3:0]    wgt_data;
   logic          wgt_drop;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   composite;
   logic [15:0]   index;
   logic          warning;
   logic          alert;
   logic          busy;

   int            total = 0;
   int            bad   = 0;
   int unsigned   m_w [8][5];
   bit            m_warn;
   int            m_cnt;
   logic [31:0]   dv [5];
   logic [31:0]   r_comp;
   logic [15:0]   r_idx;
   logic          r_warn;
   logic          r_alert;

   always #5 clk = ~clk;

   xrog_orbit_stability_mc #(
      .NUM_CH(5), .DRIFT_W(32), .NUM_ORBIT(8), .WGT_W(4), .ALERT_CNT(3), .HYST_SHIFT(3)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .in_valid_i          (in_valid),
      .in_ready_o          (in_ready),
      .orbit_type_i        (orbit_type),
      .drift_i             (drift),
      .stability_envelope_i(env),
      .drift_threshold_i   (thr),
      .wgt_we_i            (wgt_we),
      .wgt_orbit_i         (wgt_orbit),
      .wgt_ch_i            (wgt_ch),
      .wgt_data_i          (wgt_data),
      .wgt_drop_o          (wgt_drop),
      .out_valid_o         (out_valid),
      .out_ready_i         (out_ready),
      .composite_drift_o   (composite),
      .stability_index_o   (index),
      .drift_warning_o     (warning),
      .instability_alert_o (alert),
      .busy_o              (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < 8; o++)
         for (int c = 0; c < 5; c++)
            m_w[o][c] = 1;
      m_warn = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic check_reset_values();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_comp", composite, 0);
      chk("rst_index", index, 1000);
      chk("rst_warning", warning, 0);
      chk("rst_alert", alert, 0);
      chk("rst_wgt_drop", wgt_drop, 0);
   endtask

   task automatic wr_wgt(input int o, input int c, input int v);
      @(negedge clk);
      wgt_we = 1'b1; wgt_orbit = 3'(o); wgt_ch = 3'(c); wgt_data = 4'(v);
      @(posedge clk); #1;
      chk("wgt_drop_idle", wgt_drop, 0);
      wgt_we = 1'b0;
      m_w[o][c] = v;
   endtask

   task automatic run_sample(input int orb, input int unsigned e, input int unsigned t,
                             input int hold, input bit poke);
      longint unsigned s, ws, comp, q, den;
      int reg_n, lat, k;
      s = 0; ws = 0;
      for (int c = 0; c < 5; c++) begin
         s  += longint'(dv[c]) * m_w[orb][c];
         ws += m_w[orb][c];
      end
      comp  = (ws == 0) ? 0 : s / ws;
      reg_n = (comp < e) ? 0 : (comp < t) ? 1 : 2;
      den   = (reg_n == 0) ? e : t;
      q     = (den == 0) ? 1000 : comp * 1000 / den;
      if (q > 1000) q = 1000;
      if (reg_n != 0) m_warn = 1'b1;
      else if (comp < longint'(e - (e >> 3))) m_warn = 1'b0;
      m_cnt = (reg_n == 2) ? ((m_cnt < 3) ? m_cnt + 1 : 3) : 0;

      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; orbit_type = 3'(orb);
      drift = {dv[4], dv[3], dv[2], dv[1], dv[0]};
      env = e; thr = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(posedge clk); #1;
         if (poke && cyc == 10) begin
            wgt_we = 1'b1; wgt_orbit = 3'd0; wgt_ch = 3'd0; wgt_data = 4'd7;
         end
         if (poke && cyc == 11) begin
            chk("wgt_drop_pulse", wgt_drop, 1);
            wgt_we = 1'b0;
         end
         if (poke && cyc == 12) chk("wgt_drop_end", wgt_drop, 0);
         if (cyc == 50) begin
            chk("in_ready_busy", in_ready, 0);
            chk("busy_mid", busy, 1);
         end
         if (out_valid) begin lat = cyc; break; end
      end
      chk("latency", lat, 106);
      chk("composite", composite, comp);
      chk("index", index, 1000 - q);
      chk("warning", warning, m_warn);
      chk("alert", alert, (m_cnt == 3));
      r_comp = composite; r_idx = index; r_warn = warning; r_alert = alert;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_stable", {out_valid, in_ready, composite, index},
             {1'b1, 1'b0, 32'(comp), 16'(1000 - q)});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_rise", in_ready, 1);
   endtask

   task automatic set_dv(input int unsigned a, input int unsigned b, input int unsigned c,
                         input int unsigned d, input int unsigned f);
      dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d; dv[4] = f;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; orbit_type = '0; drift = '0; env = '0; thr = '0;
      wgt_we = 1'b0; wgt_orbit = '0; wgt_ch = '0; wgt_data = '0; out_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      chk("rst_in_ready_low", in_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      check_reset_values();

      set_dv(100, 200, 300, 400, 500);
      run_sample(0, 600, 1000, 0, 0);
      chk("tp1_comp", r_comp, 300);
      chk("tp1_index", r_idx, 500);

      wr_wgt(2, 0, 3); wr_wgt(2, 1, 2); wr_wgt(2, 2, 2); wr_wgt(2, 3, 2); wr_wgt(2, 4, 1);
      set_dv(1000, 0, 0, 0, 0);
      run_sample(2, 200, 600, 0, 0);
      chk("tp2_comp", r_comp, 300);
      chk("tp2_warn_set", r_warn, 1);
      set_dv(600, 0, 0, 0, 0);
      run_sample(2, 200, 600, 0, 0);
      chk("tp2_hyst_idx", r_idx, 100);
      chk("tp2_hyst_hold", r_warn, 1);
      set_dv(567, 0, 0, 0, 0);
      run_sample(2, 200, 600, 0, 0);
      chk("tp2_hyst_clear", r_warn, 0);

      set_dv(700, 700, 700, 700, 700);
      run_sample(0, 200, 600, 0, 0);
      chk("alert_1", r_alert, 0);
      run_sample(0, 200, 600, 10, 0);
      chk("alert_2", r_alert, 0);
      run_sample(0, 200, 600, 0, 0);
      chk("alert_3", r_alert, 1);
      chk("alert_idx", r_idx, 0);
      set_dv(100, 100, 100, 100, 100);
      run_sample(0, 200, 600, 0, 0);
      chk("alert_clear", r_alert, 0);

      for (int c = 0; c < 5; c++) wr_wgt(3, c, 0);
      set_dv(5, 6, 7, 8, 9);
      run_sample(3, 500, 600, 0, 0);
      chk("zero_w_comp", r_comp, 0);
      chk("zero_w_idx", r_idx, 1000);
      run_sample(3, 0, 0, 0, 0);
      chk("zero_den_idx", r_idx, 0);

      // Abort a sample during accumulation; weights and flags must revert.
      set_dv(1000, 0, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b1; orbit_type = 3'd2; drift = {dv[4], dv[3], dv[2], dv[1], dv[0]};
      env = 200; thr = 600;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_in_ready", in_ready, 0);
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run_sample(2, 200, 600, 0, 0);
      chk("post_rst_comp", r_comp, 200);

      set_dv(3000, 3000, 3000, 3000, 3000);
      run_sample(0, 100, 200, 0, 1);
      set_dv(70, 0, 0, 0, 0);
      run_sample(0, 100, 200, 0, 0);
      chk("tbl_unchanged", r_comp, 14);

      for (int n = 0; n < 24; n++) begin
         int unsigned e, t;
         bit big;
         if ($urandom_range(0, 2) == 0) begin
            for (int w = 0; w < 2; w++)
               wr_wgt($urandom_range(0, 7), $urandom_range(0, 4),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15));
         end
         big = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < 5; c++)
            dv[c] = big ? $urandom : $urandom_range(0, 5000);
         if (big) begin
            e = $urandom; t = $urandom;
         end else begin
            e = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 4000);
            t = e + $urandom_range(0, 3000);
         end
         run_sample($urandom_range(0, 7), e, t, $urandom_range(0, 2), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xrog_orbit_stability_mc.md
# xrog_orbit_stability_mc

Multi-channel, parametrised orbit stability calculator for the XROG governance pipeline. It accepts one drift sample per handshake: N drift channels, orbit type, envelope and threshold. Weights come from a per-orbit weight table that firmware can program. A serial divider computes the weighted composite drift and a saturated 0..IDX_MAX stability index. Warning and alert flags have hysteresis and debounce, and results go out on a valid/ready stream with fixed latency.

## Interface
- NUM_CH, 5, number of drift channels
- DRIFT_W, 32, drift/envelope/threshold width
- NUM_ORBIT, 8, orbit types (weight table rows)
- WGT_W, 4, unsigned weight width
- ALERT_CNT, 3, consecutive ALERT-region results before alert asserts
- HYST_SHIFT, 3, warning clears below envelope − (envelope >> HYST_SHIFT)
- Derived: DIV_W = DRIFT_W + WGT_W + $clog2(NUM_CH) + 10; OW = $clog2(NUM_ORBIT)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in/out  1  sample handshake
- orbit_type  in  OW  orbit profile select
- drift  in  NUM_CH×DRIFT_W  per-channel drift
- stability_envelope, drift_threshold  in  DRIFT_W  region bounds
- wgt_we  in  1  weight write strobe
- wgt_orbit  in  OW  weight row
- wgt_ch  in  $clog2(NUM_CH)  weight column
- wgt_data  in  WGT_W  weight value
- wgt_drop  out  1  one-cycle pulse: write dropped (busy)
- out_valid / out_ready  out/in  1  result handshake
- composite_drift  out  DRIFT_W  weighted mean drift
- stability_index  out  16  0..1000
- drift_warning, instability_alert  out  1  flags
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE → ACCUM → DIV_C → DIV_I → OUT → IDLE. in_ready = (state==IDLE).
- Accept on in_valid && in_ready. Capture drift, orbit_type, envelope and threshold.
- ACCUM: one channel per cycle, NUM_CH cycles.
  - sum += drift[c]·w[orbit][c]
  - wsum += w[orbit][c]
- DIV_C: composite = sum / wsum, truncating. wsum==0 forces composite = 0.
- Region classification, priority in this order:
  - NORMAL if composite < envelope
  - else WARN if composite < threshold
  - else ALERT
- DIV_I: q = composite·1000 / den, with den = envelope in NORMAL and threshold otherwise.
  - den==0 forces q = IDX_MAX.
  - index = IDX_MAX − min(q, IDX_MAX). Never underflows.
- Weight table:
  - NUM_ORBIT×NUM_CH entries; every entry resets to 1.
  - Writes are honoured only when busy==0. Otherwise the write is dropped and wgt_drop pulses.
  - An orbit_type value ≥ NUM_ORBIT uses uniform weight 1.
- Flags update only on entry to OUT:
  - drift_warning sets when region ≠ NORMAL. It clears only when composite < envelope − (envelope >> HYST_SHIFT); otherwise it holds.
  - Alert counter increments (saturating at ALERT_CNT) on ALERT and zeroes on any other region.
  - instability_alert = (counter == ALERT_CNT).
- All arithmetic is unsigned with DIV_W-bit intermediates; no overflow is possible.

## Timing
- Divider is restoring, 1 bit/cycle, DIV_W+1 cycles per divide including load. Both divides always run.
- out_valid rises exactly LAT = NUM_CH + 2·(DIV_W+1) + 1 cycles after the accept edge (default 106).
- Latency is independent of data and zero divisors.
- OUT holds out_valid and all outputs stable until out_ready.
- Handshake completes at OUT with out_ready: out_valid drops next cycle and in_ready rises next cycle. No same-cycle re-accept.
- Reset values: out_valid 0, in_ready 0 during rst (1 the cycle after), composite 0, index 1000, warning 0, alert 0, counter 0, wgt_drop 0, busy 0, state IDLE.
- rst asserted mid-operation aborts the sample, discards the result, clears flags and reinitialises the weight table.

## Structure
- xrog_pkg:
  - region enum {NORMAL, WARN, ALERT}
  - state enum
  - IDX_MAX = 1000
  - SCALE = 1000
- Sub-module xrog_serial_div, parametrised on DIV_W: start/done handshake and a div-by-zero flag. It is instantiated once and reused for both divides.

## Test plan
- Uniform weights; drift 100,200,300,400,500; envelope 600, threshold 1000 → composite 300, index 500, warning 0, alert 0, out_valid at accept+106.
- Program orbit 2 weights 3,2,2,2,1; drift 1000,0,0,0,0; envelope 200, threshold 600 → composite 300, WARN, index 500, warning 1.
  - Then composite 180 → index 100, warning stays 1.
  - Then composite 170 → warning 0.
- Three consecutive samples with composite 700, threshold 600 → index 0 each time; alert 0,0,1.
  - A following NORMAL sample clears alert.
- All orbit 3 weights 0 → composite 0, index 1000. Envelope 0 with composite 0 → ALERT region path, index 0. No X and no hang.
- out_ready low for 10 cycles → outputs stable, in_ready 0; wgt_we during busy → wgt_drop pulse, table unchanged.
- rst asserted during ACCUM → all outputs at reset values; the next sample gives the correct result with uniform weights.
